// File: rtl/cnn_frame_writer.sv
// cnn_frame_writer: raster pixel stream in, ping-pong 28x28 frame store out.
// The writer fills bank wbank while the consumer reads bank rbank through a
// registered random-access port and hands each bank back with a release pulse.
// Optional build macro FRAME_CHECKSUM_EN adds frame_sum, a wrapping 32-bit sum
// of the pixels of the frame currently offered on the read side.
module cnn_frame_writer #(
  parameter int DATA_W = 32,
  parameter int IMG_X  = 28,
  parameter int IMG_Y  = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic                     frame_valid,
  input  logic                     frame_release,
  input  logic [4:0]               rd_x,
  input  logic [4:0]               rd_y,
  output logic signed [DATA_W-1:0] rd_data,
  output logic [15:0]              frame_count,
  output logic                     err_last
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [31:0]              frame_sum
`endif
);

  localparam logic [4:0] X_LAST = 5'(IMG_X - 1);
  localparam logic [4:0] Y_LAST = 5'(IMG_Y - 1);
  localparam logic [4:0] X_LIM  = 5'(IMG_X);
  localparam logic [4:0] Y_LIM  = 5'(IMG_Y);

  logic signed [DATA_W-1:0] mem [2][IMG_X][IMG_Y];

  logic       wbank;
  logic       rbank;
  logic [1:0] bank_full;
  logic [4:0] pix_x;
  logic [4:0] pix_y;

  logic accept;
  logic at_end;
  logic commit;
  logic release_ok;

  // The write bank is free unless it still holds a frame the consumer owns.
  assign s_ready     = !rst && !bank_full[wbank];
  assign frame_valid = bank_full[rbank];
  assign accept      = s_valid && s_ready;
  assign at_end      = (pix_x == X_LAST) && (pix_y == Y_LAST);
  assign commit      = accept && at_end;
  assign release_ok  = frame_release && bank_full[rbank];

  // Store every accepted pixel; the array is never cleared so it maps to RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wbank][pix_x][pix_y] <= s_data;
    end
  end

  // Write cursor, bank ownership, frame counter and framing-error pulse.
  // Commit and release can land together: commit sets the write bank while
  // release clears the read bank, and those are never the same full bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbank       <= 1'b0;
      rbank       <= 1'b0;
      bank_full   <= 2'b00;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_count <= '0;
      err_last    <= 1'b0;
    end else begin
      err_last <= 1'b0;
      if (accept) begin
        if (at_end || s_last) begin
          pix_x <= '0;
          pix_y <= '0;
        end else if (pix_y == Y_LAST) begin
          pix_y <= '0;
          pix_x <= pix_x + 5'd1;
        end else begin
          pix_y <= pix_y + 5'd1;
        end
        err_last <= at_end ? !s_last : s_last;
      end
      if (commit) begin
        bank_full[wbank] <= 1'b1;
        wbank            <= ~wbank;
        frame_count      <= frame_count + 16'd1;
      end
      if (release_ok) begin
        bank_full[rbank] <= 1'b0;
        rbank            <= ~rbank;
      end
    end
  end

  // Registered read of the consumer bank; out-of-range coordinates read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if ((rd_x < X_LIM) && (rd_y < Y_LIM)) begin
      rd_data <= mem[rbank][rd_x][rd_y];
    end else begin
      rd_data <= '0;
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [31:0] acc;
  logic [31:0] bank_sum [2];
  logic [31:0] pix32;

  assign pix32     = 32'(s_data);
  assign frame_sum = bank_sum[rbank];

  // Running sum of the frame being written, latched per bank at commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      bank_sum[0] <= '0;
      bank_sum[1] <= '0;
    end else if (accept) begin
      if (at_end) begin
        bank_sum[wbank] <= acc + pix32;
        acc             <= '0;
      end else if (s_last) begin
        acc <= '0;
      end else begin
        acc <= acc + pix32;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cnn_frame_writer.sv
// Scoreboard bench for cnn_frame_writer: stimulus pushes expected values,
// a negedge monitor pops and compares one entry per requested sample.
module tb_cnn_frame_writer;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               s_valid = 1'b0;
  logic signed [31:0] s_data = '0;
  logic               s_last = 1'b0;
  logic               s_ready;
  logic               frame_valid;
  logic               frame_release = 1'b0;
  logic [4:0]         rd_x = '0;
  logic [4:0]         rd_y = '0;
  logic signed [31:0] rd_data;
  logic [15:0]        frame_count;
  logic               err_last;
`ifdef FRAME_CHECKSUM_EN
  logic [31:0]        frame_sum;
`endif

  typedef enum int {K_RD, K_READY, K_FVALID, K_FCOUNT, K_ERRCNT, K_SUM} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  logic chk_req = 1'b0;
  logic chk_vld = 1'b0;
  int   check_count = 0;
  int   error_count = 0;
  int   err_pulses = 0;

  cnn_frame_writer dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .frame_valid   (frame_valid),
    .frame_release (frame_release),
    .rd_x          (rd_x),
    .rd_y          (rd_y),
    .rd_data       (rd_data),
    .frame_count   (frame_count),
    .err_last      (err_last)
`ifdef FRAME_CHECKSUM_EN
    ,
    .frame_sum     (frame_sum)
`endif
  );

  always #5 clk = ~clk;

  // A sample request becomes a monitor strobe for the cycle after the edge.
  always @(posedge clk) chk_vld <= chk_req;

  // Count framing-error pulses as seen on each active edge.
  always @(posedge clk) if (err_last) err_pulses++;

  // Monitor: pop the oldest expectation and compare against the DUT output.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (chk_vld) begin
      check_count++;
      if (sb_q.size() == 0) begin
        error_count++;
        $display("[TB] FAIL scoreboard_underflow: got sample, expected queued entry");
      end else begin
        e = sb_q.pop_front();
        case (e.kind)
          K_RD:     act = rd_data;
          K_READY:  act = {31'b0, s_ready};
          K_FVALID: act = {31'b0, frame_valid};
          K_FCOUNT: act = {16'b0, frame_count};
          K_ERRCNT: act = 32'(err_pulses);
`ifdef FRAME_CHECKSUM_EN
          K_SUM:    act = frame_sum;
`endif
          default:  act = 32'hDEADBEEF;
        endcase
        if (act !== e.exp) begin
          error_count++;
          $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", error_count + 1, check_count + 1);
    $fatal(1, "[TB] watchdog");
  end

  // Queue one expectation and let one clock edge pass before it is sampled.
  task automatic checkOutput(input kind_t kind, input logic [31:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    chk_req = 1'b1;
    @(posedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic readCheck(input int x, input int y, input logic [31:0] exp, input string name);
    rd_x = 5'(x);
    rd_y = 5'(y);
    checkOutput(K_RD, exp, name);
  endtask

  // Offer one pixel and hold it until the DUT takes it (bounded).
  task automatic send_pixel(input logic [31:0] d, input logic last);
    int waited;
    waited  = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && waited < 3000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!s_ready) begin
      $display("[TB] FAIL send_timeout: got s_ready=0 expected 1 within 3000 cycles");
      $display("Result: errors=%0d of %0d checks", error_count + 1, check_count + 1);
      $fatal(1, "[TB] stalled");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Stream count pixels valued base + step*i; s_last on index last_at.
  task automatic applyStimulus(input int base, input int step, input int count,
                               input int last_at, input bit rel_on_last);
    for (int i = 0; i < count; i++) begin
      frame_release = rel_on_last && (i == count - 1);
      send_pixel(32'(base + step * i), i == last_at);
      frame_release = 1'b0;
    end
  endtask

  task automatic pulse_release();
    frame_release = 1'b1;
    @(posedge clk);
    #1;
    frame_release = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // Reset state, sampled while rst is still high
    checkOutput(K_READY,  0, "reset_ready");
    checkOutput(K_RD,     0, "reset_rd_data");
    checkOutput(K_FCOUNT, 0, "reset_frame_count");
    checkOutput(K_FVALID, 0, "reset_frame_valid");
    rst = 1'b0;
    checkOutput(K_READY,  1, "ready_after_reset");

    // Frame 1: value = index, s_last on 783, lands in bank 0
    applyStimulus(0, 1, 784, 783, 1'b0);
    checkOutput(K_FVALID, 1, "f1_valid");
    checkOutput(K_FCOUNT, 1, "f1_count");
    checkOutput(K_ERRCNT, 0, "f1_no_err");
    readCheck(27, 27, 783, "f1_rd_27_27");
    readCheck(0, 5, 5, "f1_rd_0_5");
    readCheck(28, 0, 0, "f1_rd_oob_x");
    readCheck(5, 3, 143, "f1_rd_5_3");
    readCheck(0, 31, 0, "f1_rd_oob_y");
`ifdef FRAME_CHECKSUM_EN
    checkOutput(K_SUM, 32'd306936, "f1_sum");
`endif

    // Frame 2 into bank 1 without release: both banks full afterwards
    applyStimulus(10000, 1, 784, 783, 1'b0);
    s_valid = 1'b1;
    s_data  = 20000;
    s_last  = 1'b0;
    checkOutput(K_READY,  0, "full_ready_a");
    checkOutput(K_READY,  0, "full_ready_b");
    checkOutput(K_FCOUNT, 2, "f2_count");
    pulse_release();
    checkOutput(K_READY,  1, "ready_after_release");
    applyStimulus(20001, 1, 783, 782, 1'b0);
    checkOutput(K_FCOUNT, 3, "f3_count");
    checkOutput(K_FVALID, 1, "f2_valid");
    readCheck(0, 0, 10000, "f2_rd_0_0");
    readCheck(27, 27, 10783, "f2_rd_27_27");
    readCheck(13, 14, 10378, "f2_rd_13_14");

    // Hand back frame 2; frame 3 in bank 0 becomes visible
    pulse_release();
    readCheck(0, 0, 20000, "f3_rd_0_0");
    readCheck(27, 27, 20783, "f3_rd_27_27");

    // Frame 4 commits on the same edge frame 3 is released
    applyStimulus(50000, 1, 784, 783, 1'b1);
    checkOutput(K_FVALID, 1, "coincident_valid");
    checkOutput(K_FCOUNT, 4, "f4_count");
    readCheck(27, 27, 50783, "f4_rd_27_27");
    readCheck(1, 0, 50028, "f4_rd_1_0");

    // Release frame 4, then a release with nothing committed is ignored
    pulse_release();
    checkOutput(K_FVALID, 0, "empty_valid");
    pulse_release();
    checkOutput(K_FVALID, 0, "ignored_release_valid");

    // Early s_last on pixel 99 drops the partial frame
    applyStimulus(40000, 1, 100, 99, 1'b0);
    checkOutput(K_ERRCNT, 1, "early_last_err");
    checkOutput(K_FVALID, 0, "early_last_no_valid");
    checkOutput(K_FCOUNT, 4, "early_last_count");
    applyStimulus(30000, 1, 784, 783, 1'b0);
    checkOutput(K_FVALID, 1, "f5_valid");
    readCheck(0, 0, 30000, "f5_rd_0_0");
    readCheck(3, 16, 30100, "f5_rd_3_16");
    checkOutput(K_ERRCNT, 1, "f5_no_err");
    checkOutput(K_FCOUNT, 5, "f5_count");

    // Full frame without s_last still commits but flags an error
    pulse_release();
    applyStimulus(60000, 1, 784, -1, 1'b0);
    checkOutput(K_ERRCNT, 2, "no_last_err");
    checkOutput(K_FCOUNT, 6, "no_last_count");
    checkOutput(K_FVALID, 1, "no_last_valid");
    readCheck(27, 27, 60783, "f6_rd_27_27");

    // Reset in the middle of a frame discards everything
    applyStimulus(70000, 1, 50, -1, 1'b0);
    rst = 1'b1;
    checkOutput(K_READY,  0, "midreset_ready");
    checkOutput(K_FVALID, 0, "midreset_valid");
    rst = 1'b0;
    checkOutput(K_FVALID, 0, "post_reset_valid");
    checkOutput(K_FCOUNT, 0, "post_reset_count");
    checkOutput(K_READY,  1, "post_reset_ready");
`ifdef FRAME_CHECKSUM_EN
    checkOutput(K_SUM, 0, "post_reset_sum");
`endif

    // All -1 frame
    applyStimulus(-1, 0, 784, 783, 1'b0);
    checkOutput(K_FVALID, 1, "neg_valid");
    checkOutput(K_FCOUNT, 1, "neg_count");
    readCheck(4, 4, 32'hFFFFFFFF, "neg_rd_4_4");
    checkOutput(K_ERRCNT, 2, "neg_no_err");
`ifdef FRAME_CHECKSUM_EN
    checkOutput(K_SUM, 32'hFFFFFCF0, "neg_sum");
`endif

    repeat (3) @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      check_count++;
      error_count++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
